// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared state encoding, lamp constants and the state-to-lamp decode used by
// the traffic phase scheduler.
// ---------------------------------------------------------------------------
`default_nettype none

package traffic_pkg;

  // Phase codes; the numeric value is what appears on the debug phase output.
  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    AR1     = 3'd2,
    CROSS_G = 3'd3,
    CROSS_Y = 3'd4,
    AR2     = 3'd5,
    PREEMPT = 3'd6
  } state_e;

  // Lamp encodings, {red,yellow,green} one-hot.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Returns {main head, cross head} for a given phase.
  function automatic logic [5:0] head_lights(input state_e s);
    logic [5:0] l;
    l = {RED, RED};
    case (s)
      MAIN_G:  l = {GRN, RED};
      MAIN_Y:  l = {YEL, RED};
      CROSS_G: l = {RED, GRN};
      CROSS_Y: l = {RED, YEL};
      PREEMPT: l = {GRN, RED};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// 8-bit tick counter for the current phase. Cleared on phase entry, advances
// on each tick and saturates at 255. done flags a tick on which the count
// has reached the selected duration minus one.
// ---------------------------------------------------------------------------
`default_nettype none

module phase_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       tick_i,
  input  logic [7:0] dur_i,
  output logic [7:0] count_o,
  output logic       done_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear wins over a coincident tick; the count never wraps.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (tick_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // ">=" lets the main-green minimum share this compare even after saturation;
  // timed phases exit at exactly dur-1 so never see a larger count.
  assign done_o  = tick_i && (count_q >= (dur_i - 8'd1));
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
// Demand-driven two-head intersection controller. Rests on main green and
// serves the cross street on vehicle or pedestrian demand. All timing in
// 1 Hz ticks. Optional emergency preemption is built when the macro
// TLC_PREEMPT_EN is defined; otherwise the preempt input is ignored.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALL_RED_T  = 1,
  parameter int unsigned MAIN_MIN_T = 10,
  parameter int unsigned CROSS_T    = 8,
  parameter int unsigned WALK_T     = 6
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       car_req,
  input  logic       ped_req,
  input  logic       preempt,
  output logic [2:0] main_st,
  output logic [2:0] cross_st,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [7:0] YEL_D  = 8'(YELLOW_T);
  localparam logic [7:0] AR_D   = 8'(ALL_RED_T);
  localparam logic [7:0] MMIN_D = 8'(MAIN_MIN_T);
  localparam logic [7:0] CRS_D  = 8'(CROSS_T);
  localparam logic [7:0] WALK_D = 8'(WALK_T);

  state_e     state_q, state_d;
  logic       ped_pend_q, ped_pend_d;
  logic       walk_q, walk_d;
  logic       ack_q, ack_d;
  logic [2:0] main_q, main_d;
  logic [2:0] cross_q, cross_d;
  logic [7:0] dur;
  logic [7:0] count;
  logic       t_done;
  logic       clr;

`ifdef TLC_PREEMPT_EN
  // Set when cross green was cut short so AR2 hands over to PREEMPT.
  logic       pre_pend_q, pre_pend_d;
`else
  logic       unused_preempt;
  assign unused_preempt = preempt;
`endif

  // Duration of the phase currently being timed.
  always_comb begin
    dur = 8'hFF;
    case (state_q)
      MAIN_G:  dur = MMIN_D;
      MAIN_Y:  dur = YEL_D;
      AR1:     dur = AR_D;
      CROSS_G: dur = CRS_D;
      CROSS_Y: dur = YEL_D;
      AR2:     dur = AR_D;
      default: dur = 8'hFF;
    endcase
  end

  // Every state change restarts the phase count.
  assign clr = (state_d != state_q);

  phase_timer u_timer (
    .clk_i   (clk_100MHz),
    .rst_ni  (reset),
    .clr_i   (clr),
    .tick_i  (tick_1Hz),
    .dur_i   (dur),
    .count_o (count),
    .done_o  (t_done)
  );

  // Next state, pedestrian bookkeeping and registered lamp values.
  always_comb begin
    state_d    = state_q;
    ped_pend_d = ped_pend_q | ped_req;
    walk_d     = walk_q;
    ack_d      = 1'b0;
`ifdef TLC_PREEMPT_EN
    pre_pend_d = pre_pend_q;
`endif
    case (state_q)
      MAIN_G: begin
`ifdef TLC_PREEMPT_EN
        if (preempt) begin
          state_d = PREEMPT;
        end else if (t_done && (car_req || ped_pend_q)) begin
          state_d = MAIN_Y;
        end
`else
        if (t_done && (car_req || ped_pend_q)) begin
          state_d = MAIN_Y;
        end
`endif
      end
      MAIN_Y: begin
        if (t_done) state_d = AR1;
      end
      AR1: begin
        if (t_done) begin
          state_d    = CROSS_G;
          // Serve what was pending; a request on this very edge waits.
          ack_d      = ped_pend_q;
          walk_d     = ped_pend_q;
          ped_pend_d = ped_req;
        end
      end
      CROSS_G: begin
`ifdef TLC_PREEMPT_EN
        if (preempt) begin
          state_d    = CROSS_Y;
          walk_d     = 1'b0;
          pre_pend_d = 1'b1;
        end else begin
          if (tick_1Hz && (count == (WALK_D - 8'd1))) walk_d = 1'b0;
          if (t_done) begin
            state_d = CROSS_Y;
            walk_d  = 1'b0;
          end
        end
`else
        if (tick_1Hz && (count == (WALK_D - 8'd1))) walk_d = 1'b0;
        if (t_done) begin
          state_d = CROSS_Y;
          walk_d  = 1'b0;
        end
`endif
      end
      CROSS_Y: begin
        if (t_done) state_d = AR2;
      end
      AR2: begin
        if (t_done) begin
`ifdef TLC_PREEMPT_EN
          state_d    = pre_pend_q ? PREEMPT : MAIN_G;
          pre_pend_d = 1'b0;
`else
          state_d = MAIN_G;
`endif
        end
      end
`ifdef TLC_PREEMPT_EN
      PREEMPT: begin
        if (!preempt) state_d = MAIN_G;
      end
`endif
      default: state_d = AR2;
    endcase
    {main_d, cross_d} = head_lights(state_d);
  end

  // State and output registers; reset parks in all-red clearance.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q    <= AR2;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      ack_q      <= 1'b0;
      main_q     <= RED;
      cross_q    <= RED;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      ack_q      <= ack_d;
      main_q     <= main_d;
      cross_q    <= cross_d;
    end
  end

`ifdef TLC_PREEMPT_EN
  // Cut-short marker register.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      pre_pend_q <= 1'b0;
    end else begin
      pre_pend_q <= pre_pend_d;
    end
  end
`endif

  assign main_st  = main_q;
  assign cross_st = cross_q;
  assign walk     = walk_q;
  assign ped_ack  = ack_q;
  assign phase    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_scheduler
// Directed vector table plus hand sequences for reset and preemption.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       car = 1'b0;
  logic       ped = 1'b0;
  logic       pre = 1'b0;
  logic [2:0] main_st, cross_st, phase;
  logic       walk, ped_ack;

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .YELLOW_T(3), .ALL_RED_T(1), .MAIN_MIN_T(10), .CROSS_T(8), .WALK_T(6)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .tick_1Hz   (tick),
    .car_req    (car),
    .ped_req    (ped),
    .preempt    (pre),
    .main_st    (main_st),
    .cross_st   (cross_st),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .phase      (phase)
  );

  typedef struct {
    logic       rst;   // reset before this vector
    logic       ped;   // isolated ped pulse before the ticks
    logic       pt;    // ped pulse coincident with the first tick
    logic       car;
    int         nt;    // ticks to apply
    logic [2:0] ph;
    logic [2:0] m;
    logic [2:0] c;
    logic       w;
    int         ack;   // ped_ack cycles expected during the ticks
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic p, input logic pt, input logic c,
                     input int nt, input state_e ph, input logic [2:0] m,
                     input logic [2:0] cr, input logic w, input int ack);
    vec_t v;
    v.rst = rst; v.ped = p; v.pt = pt; v.car = c; v.nt = nt;
    v.ph = ph; v.m = m; v.c = cr; v.w = w; v.ack = ack;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (ped_ack === 1'b1) ack_cnt++;
    end
  endtask

  task automatic do_tick(input logic c, input logic p);
    car = c; ped = p; tick = 1'b1;
    idle(1);
    tick = 1'b0; ped = 1'b0;
    idle(9);
  endtask

  task automatic pulse_ped();
    ped = 1'b1;
    idle(1);
    ped = 1'b0;
    idle(1);
  endtask

  task automatic do_reset();
    reset = 1'b0; car = 1'b0; ped = 1'b0; pre = 1'b0; tick = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
  endtask

  task automatic ticks(input int n, input logic c);
    repeat (n) do_tick(c, 1'b0);
  endtask

  task automatic chk_state(input string tag, input state_e ph, input logic [2:0] m,
                           input logic [2:0] c, input logic w);
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".main"}, 32'(main_st), 32'(m));
    check({tag, ".cross"}, 32'(cross_st), 32'(c));
    check({tag, ".walk"}, 32'(walk), 32'(w));
  endtask

  initial begin
    // Idle resting, then car-driven full cycle.
    add(1,0,0,0, 0, AR2,     R,R,0,0);
    add(0,0,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,0,50, MAIN_G,  G,R,0,0);
    add(1,0,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,1, 9, MAIN_G,  G,R,0,0);
    add(0,0,0,1, 1, MAIN_Y,  Y,R,0,0);
    add(0,0,0,1, 2, MAIN_Y,  Y,R,0,0);
    add(0,0,0,1, 1, AR1,     R,R,0,0);
    add(0,0,0,1, 1, CROSS_G, R,G,0,0);
    add(0,0,0,1, 7, CROSS_G, R,G,0,0);
    add(0,0,0,1, 1, CROSS_Y, R,Y,0,0);
    add(0,0,0,1, 2, CROSS_Y, R,Y,0,0);
    add(0,0,0,1, 1, AR2,     R,R,0,0);
    add(0,0,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,0,20, MAIN_G,  G,R,0,0);
    // Single pedestrian request after a long rest.
    add(1,0,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,0,13, MAIN_G,  G,R,0,0);
    add(0,1,0,0, 1, MAIN_Y,  Y,R,0,0);
    add(0,0,0,0, 2, MAIN_Y,  Y,R,0,0);
    add(0,0,0,0, 1, AR1,     R,R,0,0);
    add(0,0,0,0, 1, CROSS_G, R,G,1,1);
    add(0,0,0,0, 5, CROSS_G, R,G,1,0);
    add(0,0,0,0, 1, CROSS_G, R,G,0,0);
    add(0,0,0,0, 1, CROSS_G, R,G,0,0);
    add(0,0,0,0, 1, CROSS_Y, R,Y,0,0);
    add(0,0,0,0, 3, AR2,     R,R,0,0);
    add(0,0,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,0,30, MAIN_G,  G,R,0,0);
    // Ped demand honours the main minimum; a request inside cross green waits.
    add(1,1,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,0, 9, MAIN_G,  G,R,0,0);
    add(0,0,0,0, 1, MAIN_Y,  Y,R,0,0);
    add(0,0,0,0, 3, AR1,     R,R,0,0);
    add(0,0,0,0, 1, CROSS_G, R,G,1,1);
    add(0,0,0,0, 3, CROSS_G, R,G,1,0);
    add(0,1,0,0, 2, CROSS_G, R,G,1,0);
    add(0,0,0,0, 1, CROSS_G, R,G,0,0);
    add(0,0,0,0, 2, CROSS_Y, R,Y,0,0);
    add(0,0,0,0, 3, AR2,     R,R,0,0);
    add(0,0,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,0, 9, MAIN_G,  G,R,0,0);
    add(0,0,0,0, 1, MAIN_Y,  Y,R,0,0);
    add(0,0,0,0, 3, AR1,     R,R,0,0);
    add(0,0,0,0, 1, CROSS_G, R,G,1,1);
    add(0,0,0,0, 6, CROSS_G, R,G,0,0);
    // Ped request on the cross-green entry edge is held for the next cycle.
    add(1,0,0,1, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,1,10, MAIN_Y,  Y,R,0,0);
    add(0,0,0,1, 3, AR1,     R,R,0,0);
    add(0,0,1,0, 1, CROSS_G, R,G,0,0);
    add(0,0,0,0, 8, CROSS_Y, R,Y,0,0);
    add(0,0,0,0, 3, AR2,     R,R,0,0);
    add(0,0,0,0, 1, MAIN_G,  G,R,0,0);
    add(0,0,0,0, 9, MAIN_G,  G,R,0,0);
    add(0,0,0,0, 1, MAIN_Y,  Y,R,0,0);
    add(0,0,0,0, 3, AR1,     R,R,0,0);
    add(0,0,0,0, 1, CROSS_G, R,G,1,1);

    // Reset values while reset is held.
    idle(1);
    chk_state("reset", AR2, R, R, 1'b0);
    check("reset.ack", 32'(ped_ack), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vq[i].rst) do_reset();
      if (vq[i].ped) pulse_ped();
      ack_cnt = 0;
      for (int k = 0; k < vq[i].nt; k++) do_tick(vq[i].car, (k == 0) ? vq[i].pt : 1'b0);
      chk_state(tag, state_e'(vq[i].ph), vq[i].m, vq[i].c, vq[i].w);
      check({tag, ".ackcnt"}, 32'(ack_cnt), 32'(vq[i].ack));
    end

    // Asynchronous reset in the middle of cross yellow.
    do_reset();
    ticks(1, 1'b1);
    ticks(10, 1'b1);
    ticks(3, 1'b1);
    ticks(1, 1'b1);
    ticks(8, 1'b0);
    ticks(1, 1'b0);
    chk_state("pre_rst", CROSS_Y, R, Y, 1'b0);
    #2 reset = 1'b0;
    #1 chk_state("async_rst", AR2, R, R, 1'b0);
    idle(1);
    reset = 1'b1;
    idle(1);
    ticks(1, 1'b0);
    chk_state("restart", MAIN_G, G, R, 1'b0);

`ifdef TLC_PREEMPT_EN
    // Preempt cuts cross green, clears via AR2, holds, then releases to MAIN_G.
    do_reset();
    ticks(1, 1'b1);
    ticks(10, 1'b1);
    ticks(3, 1'b1);
    ticks(1, 1'b1);
    ticks(4, 1'b0);
    chk_state("pe_cg", CROSS_G, R, G, 1'b0);
    pre = 1'b1;
    idle(1);
    chk_state("pe_cut", CROSS_Y, R, Y, 1'b0);
    ticks(3, 1'b0);
    chk_state("pe_ar2", AR2, R, R, 1'b0);
    ticks(1, 1'b0);
    chk_state("pe_in", PREEMPT, G, R, 1'b0);
    ticks(5, 1'b1);
    chk_state("pe_hold", PREEMPT, G, R, 1'b0);
    pre = 1'b0;
    idle(1);
    chk_state("pe_out", MAIN_G, G, R, 1'b0);
    ticks(9, 1'b1);
    chk_state("pe_cnt0", MAIN_G, G, R, 1'b0);
    ticks(1, 1'b1);
    chk_state("pe_min", MAIN_Y, Y, R, 1'b0);
    // Preempt from main green needs no tick.
    car = 1'b0;
    do_reset();
    ticks(1, 1'b0);
    pre = 1'b1;
    idle(1);
    chk_state("pe_mg", PREEMPT, G, R, 1'b0);
    pre = 1'b0;
    idle(1);
    chk_state("pe_mg_out", MAIN_G, G, R, 1'b0);
`else
    // Without the feature the preempt input has no effect.
    do_reset();
    ticks(1, 1'b0);
    pre = 1'b1;
    idle(3);
    chk_state("pe_ignored", MAIN_G, G, R, 1'b0);
    ticks(1, 1'b0);
    chk_state("pe_ignored2", MAIN_G, G, R, 1'b0);
    pre = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
